// File: rtl/usb_tx_scheduler_if.sv
// Purpose: byte stream from the scheduler to the FT232H USB write FSM.
// Latency: none, plain wires.
// Backpressure: a byte moves only when tx_valid && tx_ready; the master holds tx_data/tx_valid until then.
// Ports: tx_data (byte), tx_valid (byte present), tx_ready (write FSM accepts this cycle).
interface usb_tx_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_tx_scheduler.sv
// Purpose: shares the USB byte stream between IQ pages (adc_ram) and bandscope chunks (bs_ram), each framed by SYNC/type/seq.
// Latency: synchronised page edge to first tx_valid in 2 cycles when idle; RAM_LAT+1 fetch cycles per payload word.
// Backpressure: tx_ready low stalls the current byte with tx_data/tx_valid held; IQ pages arriving meanwhile count as overruns.
// Ports: usb_clock/reset; rx_on, bs_on enables; adc_ram_block/bs_ready (foreign domain, synchronised here);
//        adc_ram_rd_addr/data and bs_ram_rd_addr/data RAM read ports; tx byte stream (interface);
//        bs_done re-arm pulse; iq_overruns saturating counter; busy (not IDLE).
module usb_tx_scheduler #(
  parameter int         IQ_PAGE_WORDS  = 128,
  parameter int         BS_WORDS       = 16384,
  parameter int         BS_CHUNK_WORDS = 256,
  parameter int         RAM_LAT        = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hAA
) (
  input  logic                      usb_clock,
  input  logic                      reset,
  input  logic                      rx_on,
  input  logic                      bs_on,
  input  logic                      adc_ram_block,
  input  logic [47:0]               adc_ram_rd_data,
  output logic [7:0]                adc_ram_rd_addr,
  input  logic                      bs_ready,
  input  logic [15:0]               bs_ram_rd_data,
  output logic [14:0]               bs_ram_rd_addr,
  output logic                      bs_done,
  output logic [7:0]                iq_overruns,
  output logic                      busy,
  usb_tx_scheduler_if.master        tx
);

  localparam int LW = $clog2(RAM_LAT + 1);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, NEXT} state_t;
  state_t state, state_nxt;

  // [0],[1] form the synchroniser, [2] holds the previous synchronised value for edge detection
  logic [2:0]    blk_sync, rdy_sync;
  logic          iq_edge, bs_rise;

  logic          iq_pend, iq_page, bs_act;
  logic          cur_bs, cur_page;
  logic [7:0]    cur_type, iq_seq, bs_seq;
  logic [2:0]    byte_idx;
  logic [LW-1:0] lat_cnt;
  logic [47:0]   shreg;
  logic [15:0]   word_cnt, bs_ptr, bs_ptr_inc;
  logic          last_chunk, iq_flight, iq_set, iq_ovr;

  logic          tx_valid_c;
  logic [7:0]    tx_data_c;
  logic          start_iq, start_bs, bs_drop, hdr_acc, load_word, byte_acc;
  logic          word_next, snap_done;

  assign iq_edge    = blk_sync[2] ^ blk_sync[1];
  assign bs_rise    = rdy_sync[1] & ~rdy_sync[2];
  assign bs_ptr_inc = bs_ptr + 16'd1;
  assign last_chunk = (bs_ptr >= 16'(BS_WORDS - BS_CHUNK_WORDS));
  assign iq_flight  = (state != IDLE) && !cur_bs;

  // An edge while a page is already waiting, or while one is on the wire, means a page was
  // lost or overwritten. An in-flight page is finished regardless and does not re-arm pending.
  // An edge in the very cycle the pending page is taken is a fresh page, not a loss.
  assign iq_set = rx_on && iq_edge && (!iq_flight || iq_pend);
  assign iq_ovr = rx_on && iq_edge && (iq_flight || (iq_pend && !start_iq));

  assign adc_ram_rd_addr = {cur_page, word_cnt[6:0]};
  assign bs_ram_rd_addr  = bs_ptr[14:0];
  assign busy            = (state != IDLE);
  assign tx.tx_valid     = tx_valid_c;
  assign tx.tx_data      = tx_data_c;

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) begin
      blk_sync <= '0;
      rdy_sync <= '0;
    end else begin
      blk_sync <= {blk_sync[1:0], adc_ram_block};
      rdy_sync <= {rdy_sync[1:0], bs_ready};
    end
  end

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    start_iq   = 1'b0;
    start_bs   = 1'b0;
    bs_drop    = 1'b0;
    hdr_acc    = 1'b0;
    load_word  = 1'b0;
    byte_acc   = 1'b0;
    word_next  = 1'b0;
    snap_done  = 1'b0;
    case (state)
      IDLE: begin
        // IQ wins every decision point; chunking the bandscope bounds the IQ wait
        if (iq_pend && rx_on) begin
          start_iq  = 1'b1;
          state_nxt = HDR;
        end else if (bs_act && bs_on) begin
          start_bs  = 1'b1;
          state_nxt = HDR;
        end else if (bs_act) begin
          bs_drop = 1'b1;
        end
      end
      HDR: begin
        tx_valid_c = 1'b1;
        case (byte_idx)
          3'd0:    tx_data_c = SYNC_BYTE;
          3'd1:    tx_data_c = cur_type;
          default: tx_data_c = cur_bs ? bs_seq : iq_seq;
        endcase
        if (tx.tx_ready) begin
          hdr_acc = 1'b1;
          if (byte_idx == 3'd2) state_nxt = FETCH;
        end
      end
      FETCH: begin
        // q reflects the new address RAM_LAT edges after it changed; register it on the next edge
        if (lat_cnt == LW'(RAM_LAT)) begin
          load_word = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_valid_c = 1'b1;
        tx_data_c  = shreg[47:40];
        if (tx.tx_ready) begin
          byte_acc = 1'b1;
          if (byte_idx == (cur_bs ? 3'd1 : 3'd5)) state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (cur_bs) begin
          snap_done = (bs_ptr_inc == 16'(BS_WORDS));
          if (snap_done || (word_cnt == 16'(BS_CHUNK_WORDS - 1))) state_nxt = IDLE;
          else begin
            state_nxt = FETCH;
            word_next = 1'b1;
          end
        end else begin
          if (word_cnt == 16'(IQ_PAGE_WORDS - 1)) state_nxt = IDLE;
          else begin
            state_nxt = FETCH;
            word_next = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge usb_clock or posedge reset) begin
    if (reset) begin
      iq_pend     <= 1'b0;
      iq_page     <= 1'b0;
      iq_overruns <= 8'h00;
      bs_act      <= 1'b0;
      bs_ptr      <= '0;
      bs_done     <= 1'b0;
      cur_bs      <= 1'b0;
      cur_page    <= 1'b0;
      cur_type    <= 8'h00;
      iq_seq      <= 8'h00;
      bs_seq      <= 8'h00;
      byte_idx    <= '0;
      lat_cnt     <= '0;
      shreg       <= '0;
      word_cnt    <= '0;
    end else begin
      // page just completed is the one the receiver has left, i.e. the old block value
      if (!rx_on) iq_pend <= 1'b0;
      else if (iq_set) begin
        iq_pend <= 1'b1;
        iq_page <= blk_sync[2];
      end else if (start_iq) iq_pend <= 1'b0;

      if (iq_ovr && (iq_overruns != 8'hFF)) iq_overruns <= iq_overruns + 8'd1;

      if (bs_rise && bs_on)          bs_act <= 1'b1;
      else if (bs_drop || snap_done) bs_act <= 1'b0;

      if (bs_rise && bs_on)                   bs_ptr <= '0;
      else if ((state == NEXT) && cur_bs)     bs_ptr <= bs_ptr_inc;

      bs_done <= snap_done;

      if (start_iq || start_bs) begin
        cur_bs   <= start_bs;
        cur_type <= start_iq ? 8'h01 : (last_chunk ? 8'h03 : 8'h02);
        byte_idx <= '0;
        word_cnt <= '0;
      end
      if (start_iq) cur_page <= iq_page;

      if (hdr_acc) begin
        if (byte_idx == 3'd2) begin
          byte_idx <= '0;
          lat_cnt  <= '0;
          if (cur_bs) bs_seq <= bs_seq + 8'd1;
          else        iq_seq <= iq_seq + 8'd1;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end

      if (state == FETCH) begin
        if (load_word) begin
          shreg    <= cur_bs ? {bs_ram_rd_data, 32'h0} : adc_ram_rd_data;
          byte_idx <= '0;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end

      if (byte_acc) begin
        shreg    <= {shreg[39:0], 8'h00};
        byte_idx <= byte_idx + 3'd1;
      end

      if (word_next) begin
        word_cnt <= word_cnt + 16'd1;
        lat_cnt  <= '0;
      end
    end
  end

endmodule
